// File: rtl/spi_slave_cfg.sv
// spi_slave_cfg: SPI slave with TX holding buffer and RX output register, CPOL/CPHA/bit-order configurable.
// Define SPI_SLAVE_CFG_OVERRUN_EN to get a sticky RX overrun flag.
module spi_slave_cfg #(
  parameter int DATAWIDTH_BUS = 8,
  parameter bit CPOL = 1'b0,
  parameter bit CPHA = 1'b0,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     SPI_SLAVE_CLOCK_50,
  input  logic                     SPI_SLAVE_RESET_InHigh,
  input  logic                     SPI_SLAVE_SS_InLow,
  input  logic                     SPI_SLAVE_SCK_In,
  input  logic                     SPI_SLAVE_MOSI_In,
  input  logic [DATAWIDTH_BUS-1:0] SPI_SLAVE_txData_In,
  input  logic                     SPI_SLAVE_txValid_In,
  output logic                     SPI_SLAVE_txReady_Out,
  input  logic                     SPI_SLAVE_rxReady_In,
  output logic                     SPI_SLAVE_rxValid_Out,
  output logic [DATAWIDTH_BUS-1:0] SPI_SLAVE_rxData_Out,
  output logic                     SPI_SLAVE_MISO_Out,
  output logic                     SPI_SLAVE_busy_Out,
  output logic                     SPI_SLAVE_overrun_Out
);
  localparam int CW = $clog2(DATAWIDTH_BUS);
  localparam logic [CW-1:0] LAST = CW'(DATAWIDTH_BUS - 1);
  typedef enum logic [1:0] {IDLE, LOAD, XFER, ABORT} state_t;
  state_t state, state_nx;
  logic clk, rst;
  logic [1:0] ss_sync, sck_sync, mosi_sync, warm;
  logic ss_s, sck_s, sck_d, lead, trail, sample_q, shift_q, mosi_q, armed;
  logic smp, shf, done, accept, hold_full;
  logic [CW-1:0] cnt;
  logic [DATAWIDTH_BUS-1:0] hold, tx_sr, tx_load, tx_next, rx_sr, rx_next;
  assign clk = SPI_SLAVE_CLOCK_50;
  assign rst = SPI_SLAVE_RESET_InHigh;
  assign ss_s = ss_sync[1];
  assign sck_s = sck_sync[1];
  assign lead = (sck_s != CPOL) && (sck_d == CPOL);
  assign trail = (sck_s == CPOL) && (sck_d != CPOL);
  assign smp = (state == XFER) && !ss_s && sample_q;
  // The shift edge at bit count 0 is either the pre-first-sample edge or the tail of the previous word.
  assign shf = (state == XFER) && !ss_s && shift_q && (cnt != '0);
  assign done = smp && (cnt == LAST);
  assign accept = SPI_SLAVE_txValid_In && !hold_full;
  assign tx_load = hold_full ? hold : '1;
  assign tx_next = MSB_FIRST ? {tx_sr[DATAWIDTH_BUS-2:0], 1'b1} : {1'b1, tx_sr[DATAWIDTH_BUS-1:1]};
  assign rx_next = MSB_FIRST ? {rx_sr[DATAWIDTH_BUS-2:0], mosi_q} : {mosi_q, rx_sr[DATAWIDTH_BUS-1:1]};
  assign SPI_SLAVE_txReady_Out = !hold_full;
  assign SPI_SLAVE_busy_Out = (state != IDLE);
  // Synchronisers and edge detection; armed blocks a frame start until SS is genuinely seen high after reset.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ss_sync <= 2'b11;
      sck_sync <= {2{CPOL}};
      mosi_sync <= 2'b11;
      sck_d <= CPOL;
      sample_q <= 1'b0;
      shift_q <= 1'b0;
      mosi_q <= 1'b1;
      warm <= 2'b00;
      armed <= 1'b0;
    end else begin
      ss_sync <= {ss_sync[0], SPI_SLAVE_SS_InLow};
      sck_sync <= {sck_sync[0], SPI_SLAVE_SCK_In};
      mosi_sync <= {mosi_sync[0], SPI_SLAVE_MOSI_In};
      sck_d <= sck_s;
      sample_q <= CPHA ? trail : lead;
      shift_q <= CPHA ? lead : trail;
      mosi_q <= mosi_sync[1];
      warm <= {warm[0], 1'b1};
      armed <= armed | (ss_s & warm[1]);
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = (!ss_s && armed) ? LOAD : IDLE;
      LOAD: state_nx = XFER;
      XFER: state_nx = ss_s ? ((cnt != '0) ? ABORT : IDLE) : (done ? LOAD : XFER);
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (state != XFER) cnt <= '0;
    else if (smp) cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hold <= '0;
      hold_full <= 1'b0;
      tx_sr <= '1;
      SPI_SLAVE_MISO_Out <= 1'b1;
    end else begin
      if (accept) hold <= SPI_SLAVE_txData_In;
      hold_full <= accept | (hold_full & (state != LOAD));
      if (state == LOAD) tx_sr <= tx_load;
      else if (shf) tx_sr <= tx_next;
      if (ss_s || state == IDLE || state == ABORT) SPI_SLAVE_MISO_Out <= 1'b1;
      else if (state == LOAD) SPI_SLAVE_MISO_Out <= MSB_FIRST ? tx_load[DATAWIDTH_BUS-1] : tx_load[0];
      else if (shf) SPI_SLAVE_MISO_Out <= MSB_FIRST ? tx_next[DATAWIDTH_BUS-1] : tx_next[0];
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rx_sr <= '0;
      SPI_SLAVE_rxData_Out <= '0;
      SPI_SLAVE_rxValid_Out <= 1'b0;
    end else begin
      if (smp) rx_sr <= rx_next;
      if (done) SPI_SLAVE_rxData_Out <= rx_next;
      SPI_SLAVE_rxValid_Out <= done | (SPI_SLAVE_rxValid_Out & !SPI_SLAVE_rxReady_In);
    end
`ifdef SPI_SLAVE_CFG_OVERRUN_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) SPI_SLAVE_overrun_Out <= 1'b0;
    else if (done && SPI_SLAVE_rxValid_Out && !SPI_SLAVE_rxReady_In) SPI_SLAVE_overrun_Out <= 1'b1;
`else
  assign SPI_SLAVE_overrun_Out = 1'b0;
`endif
endmodule

// File: tb/tb_spi_slave_cfg.sv
// tb_spi_slave_cfg: scoreboard bench for spi_slave_cfg; instance 0 is mode 0 MSB-first, instance 1 is mode 3 LSB-first.
module tb_spi_slave_cfg;
  localparam int HP = 80;
`ifdef SPI_SLAVE_CFG_OVERRUN_EN
  localparam logic OVR_EXP = 1'b1;
`else
  localparam logic OVR_EXP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] ss = 2'b11, sck = 2'b10, mosi = 2'b11, tx_valid = 2'b00, rx_ready = 2'b11;
  logic [1:0] tx_ready, rx_valid, miso, busy, ovr;
  logic [7:0] tx_data [2];
  logic [7:0] rx_data [2];
  logic [7:0] txq [2][$];
  logic [7:0] rxq [2][$];
  logic [7:0] mi;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    spi_slave_cfg #(.DATAWIDTH_BUS(8), .CPOL(g == 1), .CPHA(g == 1), .MSB_FIRST(g == 0)) u (
      .SPI_SLAVE_CLOCK_50(clk),
      .SPI_SLAVE_RESET_InHigh(rst),
      .SPI_SLAVE_SS_InLow(ss[g]),
      .SPI_SLAVE_SCK_In(sck[g]),
      .SPI_SLAVE_MOSI_In(mosi[g]),
      .SPI_SLAVE_txData_In(tx_data[g]),
      .SPI_SLAVE_txValid_In(tx_valid[g]),
      .SPI_SLAVE_txReady_Out(tx_ready[g]),
      .SPI_SLAVE_rxReady_In(rx_ready[g]),
      .SPI_SLAVE_rxValid_Out(rx_valid[g]),
      .SPI_SLAVE_rxData_Out(rx_data[g]),
      .SPI_SLAVE_MISO_Out(miso[g]),
      .SPI_SLAVE_busy_Out(busy[g]),
      .SPI_SLAVE_overrun_Out(ovr[g])
    );
  end
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask
  // Monitor: every word handed to the consumer must match the oldest expected word.
  always @(negedge clk)
    for (int d = 0; d < 2; d++)
      if (rx_valid[d] && rx_ready[d]) begin
        if (rxq[d].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected dut=%0d actual=%0h expected=none", d, rx_data[d]);
        end else check($sformatf("rx_data%0d", d), rx_data[d], rxq[d].pop_front());
      end
  task automatic push(input int d, input logic [7:0] v);
    int n = 0;
    @(negedge clk);
    while (!tx_ready[d] && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready[d]) begin
      checks++;
      errors++;
      $display("FAIL tx_ready_timeout dut=%0d actual=0 expected=1", d);
      return;
    end
    tx_data[d] = v;
    tx_valid[d] = 1'b1;
    @(negedge clk);
    tx_valid[d] = 1'b0;
    txq[d].push_back(v);
    check("tx_ready_after_accept", tx_ready[d], 1'b0);
  endtask
  task automatic set_ready(input int d, input logic v);
    @(posedge clk);
    #1 rx_ready[d] = v;
  endtask
  task automatic bits(input int d, input logic [7:0] mo, input int nb, output logic [7:0] mo_in);
    mo_in = '0;
    for (int i = 0; i < nb; i++) begin
      int b;
      b = (d == 0) ? 7 - i : i;
      if (d == 0) begin
        mosi[d] = mo[b];
        #HP sck[d] = 1'b1;
        mo_in[b] = miso[d];
        #HP sck[d] = 1'b0;
      end else begin
        sck[d] = 1'b0;
        mosi[d] = mo[b];
        #HP sck[d] = 1'b1;
        mo_in[b] = miso[d];
        #HP;
      end
    end
  endtask
  task automatic xfer(input int d, input logic [7:0] mo, input bit exp_rx);
    logic [7:0] te, got;
    te = 8'hFF;
    if (txq[d].size() != 0) te = txq[d].pop_front();
    if (exp_rx) rxq[d].push_back(mo);
    bits(d, mo, 8, got);
    check($sformatf("miso_word%0d", d), got, te);
  endtask
  task automatic ss_rise(input int d, input int exp);
    int n = 0;
    @(negedge clk);
    ss[d] = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (busy[d] && n < 20);
    check("busy_drop_cycles", n, exp);
  endtask
  task automatic begin_frame(input int d);
    ss[d] = 1'b0;
    #HP;
  endtask
  task automatic end_frame(input int d);
    #HP;
    if (txq[d].size() != 0) void'(txq[d].pop_front());
    ss_rise(d, 3);
    check("miso_idle", miso[d], 1'b1);
    #HP;
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end
  initial begin
    tx_data[0] = '0;
    tx_data[1] = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_tx_ready", tx_ready[d], 1'b1);
      check("rst_rx_valid", rx_valid[d], 1'b0);
      check("rst_rx_data", rx_data[d], 8'h00);
      check("rst_miso", miso[d], 1'b1);
      check("rst_busy", busy[d], 1'b0);
      check("rst_overrun", ovr[d], 1'b0);
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    push(0, 8'hA5);
    begin_frame(0);
    xfer(0, 8'h3C, 1);
    end_frame(0);
    push(1, 8'h81);
    begin_frame(1);
    xfer(1, 8'h01, 1);
    end_frame(1);
    push(0, 8'hC3);
    begin_frame(0);
    fork
      xfer(0, 8'h96, 1);
      push(0, 8'h5E);
    join
    xfer(0, 8'hE7, 1);
    end_frame(0);
    begin_frame(0);
    fork
      xfer(0, 8'h0F, 1);
      begin
        #(HP * 6);
        check("tx_ready_empty_load", tx_ready[0], 1'b1);
      end
    join
    end_frame(0);
    set_ready(0, 1'b0);
    begin_frame(0);
    xfer(0, 8'h5A, 1);
    end_frame(0);
    push(0, 8'h99);
    void'(txq[0].pop_front());
    begin_frame(0);
    bits(0, 8'hF0, 3, mi);
    #HP;
    ss_rise(0, 4);
    check("abort_rx_valid", rx_valid[0], 1'b1);
    check("abort_rx_data", rx_data[0], 8'h5A);
    check("abort_overrun", ovr[0], 1'b0);
    check("abort_tx_ready", tx_ready[0], 1'b1);
    set_ready(0, 1'b1);
    repeat (3) @(negedge clk);
    begin_frame(0);
    xfer(0, 8'hC4, 1);
    end_frame(0);
    set_ready(0, 1'b0);
    begin_frame(0);
    xfer(0, 8'h11, 0);
    xfer(0, 8'h22, 1);
    end_frame(0);
    check("ovr_rx_data", rx_data[0], 8'h22);
    check("ovr_rx_valid", rx_valid[0], 1'b1);
    check("ovr_flag", ovr[0], OVR_EXP);
    set_ready(0, 1'b1);
    repeat (3) @(negedge clk);
    for (int f = 0; f < 24; f++) begin
      int d, nw;
      d = int'($urandom_range(0, 1));
      nw = int'($urandom_range(1, 3));
      if ($urandom_range(0, 1) == 1) push(d, 8'($urandom));
      begin_frame(d);
      for (int w = 0; w < nw; w++) xfer(d, 8'($urandom), 1);
      end_frame(d);
    end
    push(0, 8'h77);
    begin_frame(0);
    bits(0, 8'hFF, 2, mi);
    #13 rst = 1'b1;
    #1;
    check("midrst_busy", busy[0], 1'b0);
    check("midrst_miso", miso[0], 1'b1);
    check("midrst_tx_ready", tx_ready[0], 1'b1);
    txq[0].delete();
    txq[1].delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("no_start_ss_held_low", busy[0], 1'b0);
    ss[0] = 1'b1;
    #HP;
    begin_frame(0);
    xfer(0, 8'h3A, 1);
    end_frame(0);
    repeat (5) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rxq_drained", rxq[d].size(), 0);
      check("no_spurious_overrun", ovr[d], 1'b0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_slave_cfg.md
SPI_SLAVE_CFG -- requirements
Module: spi_slave_cfg

Interface
REQ-001 Parameter DATAWIDTH_BUS, default 8, word length in bits, legal range 2..32.
REQ-002 Parameter CPOL, default 0, SCK idle level.
REQ-003 Parameter CPHA, default 0; 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-004 Parameter MSB_FIRST, default 1; 1 = MSB shifted first on MOSI and MISO, 0 = LSB first.
REQ-005 SPI_SLAVE_CLOCK_50  in  1  system clock; all logic on rising edge.
REQ-006 SPI_SLAVE_RESET_InHigh  in  1  asynchronous, active-high reset.
REQ-007 SPI_SLAVE_SS_InLow  in  1  slave select, active low, asynchronous to clock.
REQ-008 SPI_SLAVE_SCK_In  in  1  SPI clock, asynchronous.
REQ-009 SPI_SLAVE_MOSI_In  in  1  master-out serial data, asynchronous.
REQ-010 SPI_SLAVE_txData_In  in  DATAWIDTH_BUS  next word to send to the master.
REQ-011 SPI_SLAVE_txValid_In  in  1  txData_In valid.
REQ-012 SPI_SLAVE_txReady_Out  out  1  TX holding buffer empty.
REQ-013 SPI_SLAVE_rxReady_In  in  1  consumer takes rxData_Out.
REQ-014 SPI_SLAVE_rxValid_Out  out  1  rxData_Out holds an unconsumed word.
REQ-015 SPI_SLAVE_rxData_Out  out  DATAWIDTH_BUS  last complete received word.
REQ-016 SPI_SLAVE_MISO_Out  out  1  master-in serial data, registered.
REQ-017 SPI_SLAVE_busy_Out  out  1  frame in progress.
REQ-018 SPI_SLAVE_overrun_Out  out  1  sticky RX overrun flag.

Function
REQ-019 SS, SCK and MOSI shall pass through 2-flop synchronisers; SCK edges are detected on the synchronised signal; sample and shift actions occur in the clock cycle after detection.
REQ-020 Leading edge = SCK transition away from CPOL; trailing edge = transition back to CPOL; the sample edge is selected by CPHA, and the shift edge is the opposite edge.
REQ-021 FSM states: IDLE (SS high), LOAD (one cycle, TX shift register loaded), XFER (counting bits), ABORT (one cycle, SS rose mid-word).
REQ-022 Transitions: IDLE->LOAD on synchronised SS low; LOAD->XFER; XFER->LOAD after the DATAWIDTH_BUS-th sample while SS is low; XFER->ABORT on SS high with bit count nonzero; XFER->IDLE on SS high with bit count zero; ABORT->IDLE.
REQ-023 The bit counter shall be $clog2(DATAWIDTH_BUS) bits wide, increment on each sample edge, and wrap to 0 after DATAWIDTH_BUS-1.
REQ-024 LOAD shall move the holding buffer into the TX shift register and empty the buffer; with the buffer empty it shall load all-ones filler.
REQ-025 MISO_Out shall present the first TX bit from the cycle after LOAD (CPHA=0 included), change only on shift edges while in XFER, and be 1 whenever SS is high.
REQ-026 TX handshake: the word is accepted when txValid_In && txReady_Out; txReady_Out deasserts the following cycle and reasserts the cycle after LOAD consumes the buffer.
REQ-027 Accept and LOAD in the same cycle: LOAD uses the prior buffer contents (filler if empty), and the accepted word is kept for the next LOAD.
REQ-028 On the final sample edge of a word, rxData_Out shall be updated with the assembled word and rxValid_Out shall be set in the same cycle.
REQ-029 rxValid_Out clears when rxReady_In is high and no new word completes that cycle; a completion coinciding with rxReady_In leaves rxValid_Out at 1 with new data and no overrun.
REQ-030 A completion while rxValid_Out is 1 and rxReady_In is 0 is an overrun: the new word overwrites rxData_Out.
REQ-031 ABORT shall discard the partial RX word, leave rxData_Out and rxValid_Out unchanged, and clear the bit counter; a TX word already loaded is lost.
REQ-032 busy_Out shall be 1 in LOAD, XFER and ABORT.

Reset
REQ-033 On reset: FSM in IDLE; counter 0; holding buffer empty; txReady_Out=1; rxValid_Out=0; rxData_Out=0; MISO_Out=1; busy_Out=0; overrun_Out=0; synchronisers reset to SS=1, SCK=CPOL, MOSI=1.
REQ-034 Reset asserted mid-frame shall take effect immediately; the first frame after release shall start only on a new SS falling edge.

Configuration
REQ-035 Macro SPI_SLAVE_CFG_OVERRUN_EN: when defined, overrun_Out sets on any overrun (REQ-030) and clears only on reset; when undefined, overrun_Out is tied to 0 and no flag register exists.

Verification
REQ-036 Mode 0, MSB first: buffer 0xA5, master sends 0x3C -> MISO bits 1,0,1,0,0,1,0,1; rxData_Out=0x3C; rxValid_Out=1.
REQ-037 Mode 3, LSB first: buffer 0x81, master sends 0x01 -> MISO bits 1,0,0,0,0,0,0,1; rxData_Out=0x01.
REQ-038 Two back-to-back words with SS held low and the buffer refilled after the first LOAD -> both TX words appear on MISO in order; two rxValid_Out events.
REQ-039 Buffer empty at LOAD -> MISO all ones for the word; txReady_Out stays 1.
REQ-040 rxReady_In=0 across two completed words (0x11 then 0x22) -> rxData_Out=0x22 and overrun_Out=1 with the macro defined, overrun_Out=0 without it.
REQ-041 SS raised after 3 bits -> ABORT for one cycle, then IDLE; rxValid_Out unchanged; the next full frame is received correctly.
